// File: rtl/atax_seq_pkg.sv
// Shared types and helpers for the ATAX stage sequencer.
// Stage selection walks a fixed-width mask upward from a given index.
package atax_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } seq_state_t;

  localparam int MAX_STAGES = 8;
  localparam int NO_STAGE   = MAX_STAGES;

  // Lowest set bit strictly above 'from', or NO_STAGE when none is left.
  function automatic int next_enabled(
    input logic [MAX_STAGES-1:0] mask,
    input int                    from
  );
    int r;
    r = NO_STAGE;
    for (int i = MAX_STAGES - 1; i >= 0; i--) begin
      if (i > from && mask[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/atax_stage_sequencer_counter.sv
// Saturating cycle counter used for per-stage and whole-run latency.
// A clear that coincides with an enable loads 1 so that cycle is counted.
module seq_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Clear, then count up and stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= en ? CNT_W'(1) : '0;
    end else if (en && r_count != '1) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/atax_stage_sequencer.sv
// Top-level start/done sequencer for a chain of ap_ctrl_hs stages.
// Launches enabled stages in order and records their latencies.
module atax_stage_sequencer
  import atax_seq_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int CNT_W      = 32,
  localparam int KW        = $clog2(NUM_STAGES) + 1
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        ap_start,
  input  logic [NUM_STAGES-1:0]       stage_mask,
  output logic                        ap_done,
  output logic                        ap_ready,
  output logic                        ap_idle,
  output logic [NUM_STAGES-1:0]       stg_start,
  input  logic [NUM_STAGES-1:0]       stg_ready,
  input  logic [NUM_STAGES-1:0]       stg_done,
  output logic [KW-1:0]               cur_stage,
  output logic [NUM_STAGES*CNT_W-1:0] stage_cycles,
  output logic [CNT_W-1:0]            run_cycles,
  output logic                        proto_err
);

  localparam logic [KW-1:0] NONE = KW'(NUM_STAGES);

  seq_state_t            r_state;
  seq_state_t            w_nstate;
  logic [KW-1:0]         r_k;
  logic [KW-1:0]         w_nk;
  logic [NUM_STAGES-1:0] r_mask;
  logic                  r_perr;

  logic [NUM_STAGES-1:0] w_onehot;
  logic                  w_accept;
  logic                  w_act;
  logic                  w_done_k;
  logic                  w_rdy_k;
  logic                  w_viol;
  int                    w_first_i;
  int                    w_next_i;
  logic [KW-1:0]         w_first;
  logic [KW-1:0]         w_next;

  assign w_first_i = next_enabled(MAX_STAGES'(stage_mask), -1);
  assign w_next_i  = next_enabled(MAX_STAGES'(r_mask), int'(r_k));
  assign w_first   = (w_first_i >= NUM_STAGES) ? NONE : KW'(w_first_i);
  assign w_next    = (w_next_i >= NUM_STAGES) ? NONE : KW'(w_next_i);

  // Shifting by NONE pushes the bit out, so no stage is selected.
  assign w_onehot = NUM_STAGES'(1) << r_k;
  assign w_accept = (r_state == S_IDLE) && ap_start;
  assign w_act    = (r_state == S_LAUNCH) || (r_state == S_WAIT);
  assign w_done_k = |(stg_done & w_onehot);
  assign w_rdy_k  = |(stg_ready & w_onehot);
  assign w_viol   = (w_act && |((stg_done | stg_ready) & ~w_onehot))
                  || (!w_act && |stg_done);

  // State register.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) r_state <= S_IDLE;
    else           r_state <= w_nstate;
  end

  // Next state and next active stage; done always wins over ready.
  always_comb begin
    w_nstate = r_state;
    w_nk     = r_k;
    unique case (r_state)
      S_IDLE: begin
        if (ap_start) begin
          w_nk     = w_first;
          w_nstate = (w_first == NONE) ? S_DONE : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (w_done_k) begin
          w_nk     = w_next;
          w_nstate = (w_next == NONE) ? S_DONE : S_LAUNCH;
        end else if (w_rdy_k) begin
          w_nstate = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_done_k) begin
          w_nk     = w_next;
          w_nstate = (w_next == NONE) ? S_DONE : S_LAUNCH;
        end
      end
      S_DONE: w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // Active stage index, latched mask and sticky protocol flag.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_k    <= NONE;
      r_mask <= '0;
      r_perr <= 1'b0;
    end else begin
      r_k    <= w_nk;
      if (w_accept) r_mask <= stage_mask;
      r_perr <= (r_perr && !w_accept) || w_viol;
    end
  end

  // Handshake outputs decode straight from the state register.
  always_comb begin
    ap_idle   = (r_state == S_IDLE);
    ap_done   = (r_state == S_DONE);
    ap_ready  = (r_state == S_DONE);
    stg_start = (r_state == S_LAUNCH) ? w_onehot : '0;
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stg
    seq_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (ap_clk),
      .rst_n (ap_rst_n),
      .clr   (w_accept),
      .en    (w_act && w_onehot[g]),
      .count (stage_cycles[g*CNT_W +: CNT_W])
    );
  end

  seq_sat_counter #(.CNT_W(CNT_W)) u_run (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .clr   (w_accept),
    .en    (w_accept || (r_state != S_IDLE)),
    .count (run_cycles)
  );

  assign cur_stage = r_k;
  assign proto_err = r_perr;

endmodule

// File: tb/tb_atax_stage_sequencer.sv
// Directed bench for atax_stage_sequencer.
// A second narrow instance covers counter saturation.
module tb_atax_stage_sequencer;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ap_start;
  logic [2:0]  stage_mask;
  logic        ap_done;
  logic        ap_ready;
  logic        ap_idle;
  logic [2:0]  stg_start;
  logic [2:0]  stg_ready;
  logic [2:0]  stg_done;
  logic [2:0]  cur_stage;
  logic [95:0] stage_cycles;
  logic [31:0] run_cycles;
  logic        proto_err;

  logic        s_start;
  logic [0:0]  s_mask;
  logic        s_done_o;
  logic        s_ready_o;
  logic        s_idle;
  logic [0:0]  s_stg_start;
  logic [0:0]  s_ready;
  logic [0:0]  s_done;
  logic [0:0]  s_cur;
  logic [3:0]  s_stage_cycles;
  logic [3:0]  s_run;
  logic        s_perr;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int  rdy_d[3];
  int  done_d[3];
  int  sc[3];
  int  dc[3];
  int  nst[3];
  int  ndone;
  int  a_cyc;
  int  done_cyc;
  int  bad_cs;
  bit  inj;

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  atax_stage_sequencer #(.NUM_STAGES(3), .CNT_W(32)) u_dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .ap_start     (ap_start),
    .stage_mask   (stage_mask),
    .ap_done      (ap_done),
    .ap_ready     (ap_ready),
    .ap_idle      (ap_idle),
    .stg_start    (stg_start),
    .stg_ready    (stg_ready),
    .stg_done     (stg_done),
    .cur_stage    (cur_stage),
    .stage_cycles (stage_cycles),
    .run_cycles   (run_cycles),
    .proto_err    (proto_err)
  );

  atax_stage_sequencer #(.NUM_STAGES(1), .CNT_W(4)) u_sat (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .ap_start     (s_start),
    .stage_mask   (s_mask),
    .ap_done      (s_done_o),
    .ap_ready     (s_ready_o),
    .ap_idle      (s_idle),
    .stg_start    (s_stg_start),
    .stg_ready    (s_ready),
    .stg_done     (s_done),
    .cur_stage    (s_cur),
    .stage_cycles (s_stage_cycles),
    .run_cycles   (s_run),
    .proto_err    (s_perr)
  );

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] scy(input int k);
    return stage_cycles[k*32 +: 32];
  endfunction

  // Host plus three well-behaved stages with programmable delays.
  task automatic do_run(input logic [2:0] m);
    bit got;
    for (int k = 0; k < 3; k++) begin
      sc[k] = -1; dc[k] = -1; nst[k] = 0;
    end
    ndone = 0; done_cyc = -1; bad_cs = 0; got = 0;
    chk("idle_before_start", ap_idle, 1);
    stage_mask = m;
    ap_start   = 1'b1;
    a_cyc      = cyc;
    for (int n = 0; n < 200 && !got; n++) begin
      tick();
      stg_ready = '0;
      stg_done  = '0;
      for (int k = 0; k < 3; k++) begin
        if (stg_start[k]) begin
          nst[k]++;
          if (sc[k] < 0) sc[k] = cyc;
          if (int'(cur_stage) != k) bad_cs++;
        end
        if (sc[k] >= 0 && dc[k] < 0) begin
          if (stg_start[k] && cyc - sc[k] >= rdy_d[k])
            stg_ready[k] = 1'b1;
          if (cyc - sc[k] == done_d[k]) begin
            stg_done[k] = 1'b1;
            dc[k] = cyc;
          end
        end
      end
      if (inj && sc[0] >= 0 && dc[0] < 0 && cyc == sc[0] + 1)
        stg_done[2] = 1'b1;
      if (ap_done) begin
        got = 1;
        ndone++;
        done_cyc = cyc;
        chk("ready_with_done", ap_ready, 1);
        ap_start  = 1'b0;
        stg_ready = '0;
        stg_done  = '0;
      end
    end
    chk("run_timeout", got, 1);
    for (int n = 0; n < 3; n++) begin
      tick();
      if (ap_done) ndone++;
    end
    chk("idle_after_run", ap_idle, 1);
    chk("cur_stage_idle", cur_stage, 3);
    chk("cur_stage_active", bad_cs, 0);
  endtask

  initial begin
    ap_rst_n = 1'b0; ap_start = 1'b0; stage_mask = '0;
    stg_ready = '0; stg_done = '0; inj = 0;
    s_start = 1'b0; s_mask = '0; s_ready = '0; s_done = '0;
    tick(); tick();

    chk("rst_idle", ap_idle, 1);
    chk("rst_done", ap_done, 0);
    chk("rst_start", stg_start, 0);
    chk("rst_cur", cur_stage, 3);
    chk("rst_run", run_cycles, 0);
    chk("rst_stage", stage_cycles, 0);
    chk("rst_perr", proto_err, 0);
    ap_rst_n = 1'b1;
    tick();

    // Normal three-stage run.
    rdy_d  = '{0, 0, 0};
    done_d = '{4, 10, 7};
    do_run(3'b111);
    chk("norm_s0_start", sc[0], a_cyc + 1);
    chk("norm_s1_start", sc[1], dc[0] + 1);
    chk("norm_s2_start", sc[2], dc[1] + 1);
    chk("norm_done_at", done_cyc, a_cyc + 25);
    chk("norm_ndone", ndone, 1);
    chk("norm_sc0", scy(0), 5);
    chk("norm_sc1", scy(1), 11);
    chk("norm_sc2", scy(2), 8);
    chk("norm_run", run_cycles, 26);
    chk("norm_perr", proto_err, 0);
    tick(); tick();
    chk("norm_hold_run", run_cycles, 26);
    chk("norm_hold_sc1", scy(1), 11);

    // Ready held off three cycles plus a stray done on stage 2.
    rdy_d  = '{3, 0, 0};
    done_d = '{5, 2, 1};
    inj    = 1;
    do_run(3'b111);
    inj    = 0;
    chk("rdly_nstart0", nst[0], 4);
    chk("rdly_perr", proto_err, 1);
    chk("rdly_ndone", ndone, 1);
    chk("rdly_sc0", scy(0), 6);
    chk("rdly_sc1", scy(1), 3);
    chk("rdly_sc2", scy(2), 2);
    chk("rdly_run", run_cycles, 13);
    chk("rdly_s1_start", sc[1], dc[0] + 1);

    // Sparse mask; also shows proto_err clears on acceptance.
    rdy_d  = '{0, 0, 0};
    done_d = '{4, 3, 7};
    do_run(3'b101);
    chk("sparse_nstart1", nst[1], 0);
    chk("sparse_sc1", scy(1), 0);
    chk("sparse_s2_start", sc[2], dc[0] + 1);
    chk("sparse_sc0", scy(0), 5);
    chk("sparse_sc2", scy(2), 8);
    chk("sparse_run", run_cycles, 15);
    chk("sparse_perr", proto_err, 0);

    // Empty mask, start left high so a second run follows back to back.
    stage_mask = 3'b000;
    ap_start   = 1'b1;
    tick();
    chk("empty_done_a1", ap_done, 1);
    chk("empty_ready_a1", ap_ready, 1);
    chk("empty_nostart", stg_start, 0);
    tick();
    chk("b2b_idle", ap_idle, 1);
    chk("b2b_nodone", ap_done, 0);
    chk("empty_run", run_cycles, 2);
    tick();
    chk("b2b_done", ap_done, 1);
    ap_start = 1'b0;
    tick();
    chk("b2b_run", run_cycles, 2);
    chk("b2b_idle_end", ap_idle, 1);

    // Reset while stage 1 is waiting for done.
    stage_mask = 3'b111;
    ap_start   = 1'b1;
    tick();
    stg_ready = 3'b001; stg_done = 3'b001;
    tick();
    stg_ready = 3'b010; stg_done = 3'b000;
    tick();
    stg_ready = 3'b000;
    tick();
    chk("mid_cur1", cur_stage, 1);
    chk("mid_nostart", stg_start, 0);
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    tick();
    chk("mrst_idle", ap_idle, 1);
    chk("mrst_start", stg_start, 0);
    chk("mrst_done", ap_done, 0);
    chk("mrst_run", run_cycles, 0);
    chk("mrst_stage", stage_cycles, 0);
    chk("mrst_cur", cur_stage, 3);
    ap_rst_n = 1'b1;
    tick();
    chk("mrst_done2", ap_done, 0);

    // Fresh run with zero-latency stages.
    rdy_d  = '{0, 0, 0};
    done_d = '{0, 0, 0};
    do_run(3'b111);
    chk("zl_s0", sc[0], a_cyc + 1);
    chk("zl_s1", sc[1], a_cyc + 2);
    chk("zl_s2", sc[2], a_cyc + 3);
    chk("zl_done", done_cyc, a_cyc + 4);
    chk("zl_run", run_cycles, 5);
    chk("zl_sc0", scy(0), 1);
    chk("zl_sc1", scy(1), 1);
    chk("zl_sc2", scy(2), 1);

    // Saturation on a 4-bit instance with a 20-cycle stage.
    s_mask  = 1'b1;
    s_start = 1'b1;
    tick();
    chk("sat_start", s_stg_start, 1);
    for (int i = 0; i < 20; i++) begin
      s_ready = s_stg_start;
      s_done  = (i == 19) ? 1'b1 : 1'b0;
      tick();
    end
    chk("sat_done", s_done_o, 1);
    s_start = 1'b0;
    s_ready = '0;
    s_done  = '0;
    tick(); tick();
    chk("sat_stage", s_stage_cycles, 15);
    chk("sat_run", s_run, 15);
    chk("sat_perr", s_perr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/atax_stage_sequencer.md
# atax_stage_sequencer

Top-level control sequencer for a chain of `ap_ctrl_hs` sub-blocks, such as the three pipelined loop kernels of an HLS accelerator. It is started through a standard top-level start/done handshake. It launches each enabled stage in order, waits for that stage's done, then advances to the next. It also records per-stage and whole-run cycle counts, which dataflow/latency monitors and software use to characterise each run.

## Interface
- `NUM_STAGES`, 3: number of sequenced sub-blocks, 1..8.
- `CNT_W`, 32: width of every cycle counter.
- `ap_clk  in  1`: sole clock; everything is sampled on the rising edge.
- `ap_rst_n  in  1`: reset, synchronous, active-low.
- `ap_start  in  1`: run request; held high by the host until `ap_ready`.
- `stage_mask  in  NUM_STAGES`: bit k=1 enables stage k; sampled only at acceptance.
- `ap_done  out  1`: one-cycle pulse when the run completes.
- `ap_ready  out  1`: one-cycle pulse, identical to `ap_done` (non-pipelined top).
- `ap_idle  out  1`: high only in IDLE.
- `stg_start  out  NUM_STAGES`: per-stage start, one-hot or zero.
- `stg_ready  in  NUM_STAGES`: per-stage ready; stage has consumed its start.
- `stg_done  in  NUM_STAGES`: per-stage done pulse.
- `cur_stage  out  $clog2(NUM_STAGES)+1`: index of the active stage; `NUM_STAGES` when none is active.
- `stage_cycles  out  NUM_STAGES*CNT_W`: stage k latency, in bits [k*CNT_W +: CNT_W].
- `run_cycles  out  CNT_W`: whole-run latency.
- `proto_err  out  1`: sticky protocol-violation flag.

## Operation
- **FSM states:** IDLE, LAUNCH, WAIT, DONE.
- **IDLE:**
  - Condition: `ap_idle`=1.
  - On `ap_start`=1 (acceptance cycle A):
    - latch `stage_mask`;
    - clear all counters and `proto_err`;
    - select the lowest enabled stage k and go to LAUNCH.
  - If the latched mask is 0, go directly to DONE.
- **LAUNCH:**
  - Drive `stg_start[k]`=1.
  - On `stg_ready[k]`, drop the start and go to WAIT.
  - If `stg_done[k]` arrives together with `stg_ready[k]`, treat it as completion: advance exactly as WAIT would, with no WAIT cycle.
  - `stg_done[k]` without `stg_ready[k]` also completes the stage (ready implied); `stg_start` is dropped.
- **WAIT:**
  - On `stg_done[k]`, select the next higher enabled stage and go to LAUNCH.
  - If no enabled stage remains, go to DONE.
- **DONE:**
  - `ap_done`=`ap_ready`=1 for one cycle, then IDLE.
  - Counters hold their values until the next acceptance.
- **Stage counter k:**
  - Counts every cycle from the first `stg_start[k]` cycle through the `stg_done[k]` cycle, inclusive. Minimum value is 1.
  - Saturates at 2^CNT_W−1.
  - Disabled stages read 0.
- **Run counter:** counts acceptance cycle A through the DONE cycle, inclusive; saturating.
- **`proto_err` set conditions:**
  - any `stg_done[j]` or `stg_ready[j]` for j≠k while active;
  - any `stg_done` in IDLE or DONE.

  Offending inputs are otherwise ignored.
- **Reset:** every state and output is cleared to zero, except `ap_idle`=1 and `cur_stage`=`NUM_STAGES`. Reset mid-run abandons the run: no `ap_done`, and `stg_start` drops in the same edge.

## Timing
- Acceptance at cycle A gives the first `stg_start` at A+1.
- Stage done at cycle D gives the next `stg_start` at D+1, or `ap_done` at D+1 for the last stage.
- **Zero-latency stages:** three enabled stages, each asserting ready+done in their start cycle.
  - Starts at A+1, A+2, A+3; `ap_done` at A+4.
  - `run_cycles`=5; each `stage_cycles`=1.
- **Empty mask:** `ap_done` at A+1, `run_cycles`=2.
- **Back-to-back runs:** `ap_start` still high in the cycle after DONE is accepted as a new run at that cycle. IDLE is occupied for at least one cycle, so the `ap_idle` pulse is visible.
- Outputs are registered except `ap_idle`, `ap_done`, `ap_ready` and `stg_start`, which decode directly from registered state.

## Structure
- **Package `atax_seq_pkg`:**
  - `seq_state_t` enum (IDLE, LAUNCH, WAIT, DONE);
  - `NO_STAGE` constant;
  - function `next_enabled(mask, from)` returning the next set bit above `from`, or `NO_STAGE`.
- **Sub-module `seq_sat_counter`:**
  - parameter `CNT_W`;
  - ports `clr`, `en`, `count`;
  - saturating; instantiated `NUM_STAGES`+1 times.

## Test plan
- **Normal sequence:** mask=3'b111; stage k returns ready at start+0 and done at start+{4,10,7}. Required: `stage_cycles`={5,11,8}, `ap_done` once, `run_cycles`=26, `proto_err`=0.
- **Sparse mask:** mask=3'b101. Required: `stg_start[1]` never asserts; `stage_cycles[1]`=0; stage 2 starts the cycle after stage 0 done.
- **Empty mask:** mask=0 with `ap_start`. Required: `ap_done`/`ap_ready` at A+1, `run_cycles`=2, no `stg_start`.
- **Ready delay and protocol errors:**
  - `stg_ready[0]` held low for 3 cycles. Required: `stg_start[0]` held 4 cycles.
  - Inject `stg_done[2]` while stage 0 is active. Required: `proto_err`=1, sequence unaffected.
- **Saturation:** `CNT_W`=4 with a stage latency of 20. Required: `stage_cycles`=15, `run_cycles`=15.
- **Reset mid-run:** `ap_rst_n`=0 during stage 1 WAIT. Required: next edge gives `ap_idle`=1, all `stg_start`=0, counters 0, no `ap_done`. A fresh run then completes normally.
